// File: rtl/seq_gen_pkg.sv
// Shared definitions for the 3-bit symbol stream: symbol width, idle symbol, FSM states.
package seq_gen_pkg;

  localparam int unsigned SYM_W = 3;
  localparam logic [SYM_W-1:0] IDLE_SYM = 3'b000;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SEND = 2'd1;
  localparam state_t S_GAP  = 2'd2;
  localparam state_t S_DONE = 2'd3;

endpackage

// File: rtl/seq_pattern_mem.sv
// Pattern register file: one synchronous write port, one asynchronous read port, no reset.
module seq_pattern_mem #(
  parameter int unsigned SYM_W = seq_gen_pkg::SYM_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [SYM_W-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [SYM_W-1:0]           rdata
);
  import seq_gen_pkg::*;

  logic [SYM_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sequence_generator.sv
// Replays a programmed symbol pattern over a valid/ready link, with repeats and idle gaps.
module sequence_generator #(
  parameter int unsigned SYM_W = seq_gen_pkg::SYM_W,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP_W = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [SYM_W-1:0]           load_data,
  input  logic [$clog2(DEPTH):0]     seq_len,
  input  logic [GAP_W-1:0]           gap_cycles,
  input  logic [REP_W-1:0]           repeat_cnt,
  input  logic                       start,
  input  logic                       abort,
  output logic [SYM_W-1:0]           data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   sym_index
);
  import seq_gen_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LW-1:0]    len_q, len_d;
  logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
  logic [REP_W-1:0] rep_q, rep_d;

  logic [SYM_W-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AW-1:0]    sym_index_q, sym_index_d;

  logic             mem_we_c;
  logic [SYM_W-1:0] mem_rdata_c;
  logic             xfer_c;
  logic             last_c;

  // Writes only while idle so the pattern cannot change under a running stream.
  assign mem_we_c = load_en && (state_q == S_IDLE);

  // Read at the next index so the registered data_out lines up with sym_index.
  seq_pattern_mem #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (idx_d),
    .rdata (mem_rdata_c)
  );

  assign xfer_c = (state_q == S_SEND) && data_ready;
  assign last_c = (LW'(idx_q) == (len_q - LW'(1)));

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    gap_d     = gap_q;
    len_d     = len_q;
    gap_cfg_d = gap_cfg_q;
    rep_d     = rep_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort && (seq_len != '0)) begin
          len_d     = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
          gap_cfg_d = gap_cycles;
          rep_d     = repeat_cnt;
          idx_d     = '0;
          pass_d    = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer_c) begin
          if (!last_c) begin
            idx_d = idx_q + AW'(1);
          end else if (pass_q == rep_q) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d  = '0;
            pass_d = pass_q + REP_W'(1);
            if (gap_cfg_q != '0) begin
              gap_d   = gap_cfg_q;
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      pass_d  = '0;
      gap_d   = '0;
    end

    data_valid_d = (state_d == S_SEND);
    data_out_d   = data_valid_d ? mem_rdata_c : SYM_W'(IDLE_SYM);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    sym_index_d  = idx_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pass_q       <= '0;
      gap_q        <= '0;
      len_q        <= '0;
      gap_cfg_q    <= '0;
      rep_q        <= '0;
      data_out_q   <= SYM_W'(IDLE_SYM);
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sym_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      gap_q        <= gap_d;
      len_q        <= len_d;
      gap_cfg_q    <= gap_cfg_d;
      rep_q        <= rep_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sym_index_q  <= sym_index_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sym_index  = sym_index_q;

endmodule
